// File: rtl/rotate_restorer.sv
// ============================================================================
// Module   : rotate_restorer
// Purpose  : Button front end for the 16-bit rotate datapath. Debounces the
//            board buttons, holds the working word, applies left/right
//            rotations by 1 or 2 and tracks the net left rotation mod 16.
//            A restore request walks the word back to the loaded value one
//            bit per cycle along the shorter direction.
// Ports    : clk, rst_n (async, active low)
//            sw[15:0]                 value captured on load
//            BTNU/BTNL/BTNR/BTND      load / rotate left / right / restore
//            BTNC                     level: rotate by 2 instead of 1
//            led[15:0]                current word
//            offset[3:0]              net left rotation mod 16
//            busy                     high while restoring
//            restore_done             one-cycle pulse when restore completes
//            shift_count[15:0]        (ROT_COUNT_EN only) accepted rotations
// Options  : define ROT_COUNT_EN to add the saturating shift_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotate_restorer #(
  parameter int DEB_CYCLES = 500000,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             BTNU,
  input  logic             BTNL,
  input  logic             BTNR,
  input  logic             BTNC,
  input  logic             BTND,
  output logic [WIDTH-1:0] led,
  output logic [3:0]       offset,
  output logic             busy,
  output logic             restore_done
`ifdef ROT_COUNT_EN
  ,
  output logic [15:0]      shift_count
`endif
);

  localparam int NBTN = 5;
  localparam int B_U  = 0;
  localparam int B_L  = 1;
  localparam int B_R  = 2;
  localparam int B_C  = 3;
  localparam int B_D  = 4;

  localparam int                CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTORE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  deb_q, deb_d, deb_prev_q;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];

  assign btn_raw = {BTND, BTNC, BTNR, BTNL, BTNU};

  // The debounced level follows the synchronized input only after they have
  // disagreed for DEB_CYCLES consecutive cycles; any agreeing cycle restarts.
  always_comb begin
    for (int b = 0; b < NBTN; b++) begin
      cnt_d[b] = cnt_q[b];
      deb_d[b] = deb_q[b];
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DEB_LAST) begin
          deb_d[b] = sync2_q[b];
          cnt_d[b] = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int b = 0; b < NBTN; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int b = 0; b < NBTN; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  logic press_u, press_l, press_r, press_d;
  assign press_u = deb_q[B_U] & ~deb_prev_q[B_U];
  assign press_l = deb_q[B_L] & ~deb_prev_q[B_L];
  assign press_r = deb_q[B_R] & ~deb_prev_q[B_R];
  assign press_d = deb_q[B_D] & ~deb_prev_q[B_D];

  // --------------------------------------------------------------------------
  // Datapath and control
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [3:0]       offset_q, offset_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] rotl1, rotl2, rotr1, rotr2;
  logic             step2;

  assign rotl1 = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
  assign rotl2 = {led_q[WIDTH-3:0], led_q[WIDTH-1:WIDTH-2]};
  assign rotr1 = {led_q[0],   led_q[WIDTH-1:1]};
  assign rotr2 = {led_q[1:0], led_q[WIDTH-1:2]};
  assign step2 = deb_q[B_C];

`ifdef ROT_COUNT_EN
  logic [15:0] scount_q, scount_d;
  logic [15:0] scount_inc;
  assign scount_inc = (scount_q == 16'hFFFF) ? scount_q : scount_q + 16'd1;
`endif

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    offset_d = offset_q;
`ifdef ROT_COUNT_EN
    scount_d = scount_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (press_u) begin
          led_d    = sw;
          offset_d = 4'd0;
`ifdef ROT_COUNT_EN
          scount_d = 16'd0;
`endif
        end else if (press_d) begin
          state_d = (offset_q == 4'd0) ? S_DONE : S_RESTORE;
        end else if (press_l && press_r) begin
          // Opposing requests cancel; nothing changes.
          state_d = S_IDLE;
        end else if (press_l) begin
          led_d    = step2 ? rotl2 : rotl1;
          offset_d = offset_q + (step2 ? 4'd2 : 4'd1);
`ifdef ROT_COUNT_EN
          scount_d = scount_inc;
`endif
        end else if (press_r) begin
          led_d    = step2 ? rotr2 : rotr1;
          offset_d = offset_q - (step2 ? 4'd2 : 4'd1);
`ifdef ROT_COUNT_EN
          scount_d = scount_inc;
`endif
        end
      end
      S_RESTORE: begin
        // Offsets 1..8 are closer going right, 9..15 closer going left.
        if (offset_q == 4'd0) begin
          state_d = S_DONE;
        end else if (offset_q <= 4'd8) begin
          led_d    = rotr1;
          offset_d = offset_q - 4'd1;
        end else begin
          led_d    = rotl1;
          offset_d = offset_q + 4'd1;
        end
        if (offset_d == 4'd0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      led_q    <= '0;
      offset_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      offset_q <= offset_d;
      busy_q   <= (state_d == S_RESTORE);
      done_q   <= (state_d == S_DONE);
    end
  end

`ifdef ROT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scount_q <= 16'd0;
    else        scount_q <= scount_d;
  end
  assign shift_count = scount_q;
`endif

  assign led          = led_q;
  assign offset       = offset_q;
  assign busy         = busy_q;
  assign restore_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rotate_restorer.sv
// ============================================================================
// Module   : tb_rotate_restorer
// Purpose  : Directed self-checking bench for rotate_restorer (DEB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotate_restorer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0;
  logic        BTNU = 1'b0, BTNL = 1'b0, BTNR = 1'b0, BTNC = 1'b0, BTND = 1'b0;
  logic [15:0] led;
  logic [3:0]  offset;
  logic        busy, restore_done;
`ifdef ROT_COUNT_EN
  logic [15:0] shift_count;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  rotate_restorer #(.DEB_CYCLES(4), .WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .BTNU         (BTNU),
    .BTNL         (BTNL),
    .BTNR         (BTNR),
    .BTNC         (BTNC),
    .BTND         (BTND),
    .led          (led),
    .offset       (offset),
    .busy         (busy),
    .restore_done (restore_done)
`ifdef ROT_COUNT_EN
    ,
    .shift_count  (shift_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a button long enough to debounce, then release and let it settle.
  task automatic press(input int b);
    case (b)
      0: BTNU = 1'b1;
      1: BTNL = 1'b1;
      2: BTNR = 1'b1;
      default: BTND = 1'b1;
    endcase
    tick(8);
    BTNU = 1'b0; BTNL = 1'b0; BTNR = 1'b0; BTND = 1'b0;
    tick(8);
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy !== 1'b1 && cnt < 30) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (restore_done !== 1'b1 && cnt < 30) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_led", led, 16'h0000);
    check("rst_offset", offset, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", restore_done, 1'b0);
`ifdef ROT_COUNT_EN
    check("rst_count", shift_count, 16'd0);
`endif
    rst_n = 1'b1;
    tick(2);

    // Load and left rotate, with exact latency from the raw press
    sw = 16'h0001;
    press(0);
    check("load_led", led, 16'h0001);
    BTNL = 1'b1;
    tick(6);
    check("left_not_yet", led, 16'h0001);
    tick(1);
    check("left_led", led, 16'h0002);
    check("left_offset", offset, 4'd1);
    BTNL = 1'b0;
    tick(8);

    // Step-2 right rotate
    press(0);
    check("reload_offset", offset, 4'd0);
    BTNC = 1'b1;
    tick(8);
    press(2);
    check("r2_led", led, 16'h4000);
    check("r2_offset", offset, 4'd14);
    BTNC = 1'b0;
    tick(8);

    // Short-path restore from offset 14: two left steps
    BTND = 1'b1;
    wait_busy(n);
    check("rs_busy_seen", busy, 1'b1);
    check("rs_led0", led, 16'h4000);
    tick(1);
    check("rs_led1", led, 16'h8000);
    check("rs_busy1", busy, 1'b1);
    tick(1);
    check("rs_led2", led, 16'h0001);
    check("rs_offset2", offset, 4'd0);
    check("rs_busy2", busy, 1'b0);
    check("rs_done2", restore_done, 1'b1);
    tick(1);
    check("rs_done_pulse", restore_done, 1'b0);
    BTND = 1'b0;
    tick(8);

    // Zero-offset restore
    BTND = 1'b1;
    wait_done(n);
    check("z_done_seen", restore_done, 1'b1);
    check("z_busy", busy, 1'b0);
    check("z_led", led, 16'h0001);
    tick(1);
    check("z_done_pulse", restore_done, 1'b0);
    BTND = 1'b0;
    tick(8);

    // Simultaneous L and R presses cancel
    BTNL = 1'b1;
    BTNR = 1'b1;
    tick(8);
    BTNL = 1'b0;
    BTNR = 1'b0;
    tick(8);
    check("lr_led", led, 16'h0001);
    check("lr_offset", offset, 4'd0);

    // Glitch of DEB_CYCLES-1 cycles is rejected
    BTNL = 1'b1;
    tick(3);
    BTNL = 1'b0;
    tick(10);
    check("glitch_led", led, 16'h0001);
    check("glitch_offset", offset, 4'd0);

    // Four step-2 lefts reach offset 8
    BTNC = 1'b1;
    tick(8);
    for (int i = 0; i < 4; i++) press(1);
    check("l8_led", led, 16'h0100);
    check("l8_offset", offset, 4'd8);
    BTNC = 1'b0;
    tick(8);
`ifdef ROT_COUNT_EN
    check("count5", shift_count, 16'd5);
`endif

    // Offset 8 restore takes 8 steps; a BTNL during it is dropped
    BTND = 1'b1;
    wait_busy(n);
    check("o8_busy_seen", busy, 1'b1);
    BTNL = 1'b1;
    tick(1);
    check("o8_step1_led", led, 16'h0080);
    check("o8_step1_off", offset, 4'd7);
    wait_done(n);
    check("o8_steps_left", n, 7);
    check("o8_done_led", led, 16'h0001);
    BTNL = 1'b0;
    BTND = 1'b0;
    tick(10);
    check("drop_led", led, 16'h0001);
    check("drop_offset", offset, 4'd0);

    // Reset in the middle of a restore
    sw = 16'h00F0;
    press(0);
`ifdef ROT_COUNT_EN
    check("count_cleared", shift_count, 16'd0);
`endif
    for (int i = 0; i < 3; i++) press(1);
    check("mr_led", led, 16'h0780);
    check("mr_offset", offset, 4'd3);
`ifdef ROT_COUNT_EN
    check("count3", shift_count, 16'd3);
`endif
    BTND = 1'b1;
    wait_busy(n);
    tick(1);
    check("mr_step_led", led, 16'h03C0);
    check("mr_step_off", offset, 4'd2);
    #2;
    rst_n = 1'b0;
    BTND = 1'b0;
    #1;
    check("mr_rst_led", led, 16'h0000);
    check("mr_rst_offset", offset, 4'd0);
    check("mr_rst_busy", busy, 1'b0);
    check("mr_rst_done", restore_done, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("post_rst_led", led, 16'h0000);
    check("post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
